// File: rtl/opendap_ap_mux.sv
`default_nettype none
// ============================================================================
// Module   : opendap_ap_mux
// Purpose  : Routes DP access-port transactions to one of N_APS downstream
//            APs selected by APSEL. At most one downstream access is in
//            flight. A nonexistent APSEL completes locally after one cycle.
//            The last read data is held on up_rdata_o until the next accept.
// Ports    : swclk_i, rst_ni    - clock, asynchronous active-low reset
//            up_*_i / up_*_o    - upstream (DP side) request and response
//            dn_*_o / dn_*_i    - downstream AP slots; slot i of dn_rdata_i
//                                 occupies bits [32i+31:32i]
// Revision : 1.0 - initial release
// ============================================================================
module opendap_ap_mux #(
  parameter int N_APS       = 2,    // number of downstream APs, 1..8
  parameter bit BAD_SEL_ERR = 1'b1  // error response on a nonexistent APSEL
) (
  input  logic                  swclk_i,
  input  logic                  rst_ni,
  // upstream (DP side)
  input  logic [7:0]            up_sel_i,
  input  logic [5:0]            up_addr_i,
  input  logic [31:0]           up_wdata_i,
  input  logic                  up_wen_i,
  input  logic                  up_ren_i,
  input  logic                  up_abort_i,
  output logic [31:0]           up_rdata_o,
  output logic                  up_rdy_o,
  output logic                  up_err_o,
  // downstream (AP side)
  output logic [5:0]            dn_addr_o,
  output logic [31:0]           dn_wdata_o,
  output logic [N_APS-1:0]      dn_wen_o,
  output logic [N_APS-1:0]      dn_ren_o,
  output logic [N_APS-1:0]      dn_abort_o,
  input  logic [32*N_APS-1:0]   dn_rdata_i,
  input  logic [N_APS-1:0]      dn_rdy_i,
  input  logic [N_APS-1:0]      dn_err_i
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_BUSY   = 2'd1,
    ST_BADSEL = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic [2:0]  idx_q, idx_d;
  logic [31:0] rdata_q, rdata_d;

  logic             w_sel_valid;
  logic [N_APS-1:0] w_sel_oh;   // one-hot decode of up_sel_i
  logic [N_APS-1:0] w_idx_oh;   // one-hot decode of the latched index
  logic             w_slot_rdy;
  logic             w_slot_err;
  logic [31:0]      w_slot_rdata;
  logic             w_accept;
  logic             w_complete;

  assign w_sel_valid = (up_sel_i < 8'(N_APS));

  // Slot selection is an AND-OR mux over decoded one-hots rather than an
  // indexed read, so X on any non-selected slot never reaches the outputs
  // and an out-of-range index can never be formed.
  always_comb begin
    w_sel_oh     = '0;
    w_idx_oh     = '0;
    w_slot_rdata = '0;
    for (int i = 0; i < N_APS; i++) begin
      w_sel_oh[i] = (up_sel_i == 8'(i));
      w_idx_oh[i] = (idx_q == 3'(i));
    end
    for (int i = 0; i < N_APS; i++) begin
      w_slot_rdata = w_slot_rdata | (dn_rdata_i[32*i +: 32] & {32{w_idx_oh[i]}});
    end
  end

  assign w_slot_rdy = |(dn_rdy_i & w_idx_oh);
  assign w_slot_err = |(dn_err_i & w_idx_oh);

  // Upstream response
  always_comb begin
    up_rdy_o   = 1'b1;
    up_err_o   = 1'b0;
    up_rdata_o = rdata_q;
    case (state_q)
      ST_BUSY: begin
        up_rdy_o   = w_slot_rdy;
        up_err_o   = w_slot_err && w_slot_rdy;
        up_rdata_o = w_slot_rdata;
      end
      ST_BADSEL: begin
        up_err_o   = BAD_SEL_ERR;
        up_rdata_o = '0;
      end
      default: ;
    endcase
  end

  // An abort cycle swallows any simultaneous strobe.
  assign w_accept   = (up_wen_i || up_ren_i) && up_rdy_o && !up_abort_i;
  assign w_complete = (state_q == ST_BUSY) && w_slot_rdy;

  // Downstream forwarding is combinational in the accept cycle.
  assign dn_addr_o  = up_addr_i;
  assign dn_wdata_o = up_wdata_i;
  assign dn_wen_o   = (w_accept && up_wen_i && w_sel_valid) ? w_sel_oh : '0;
  assign dn_ren_o   = (w_accept && up_ren_i && w_sel_valid) ? w_sel_oh : '0;
  assign dn_abort_o = {N_APS{up_abort_i}};

  // Next-state logic
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    rdata_d = rdata_q;
    if (up_abort_i) begin
      state_d = ST_IDLE;
    end else begin
      if (w_complete) begin
        rdata_d = w_slot_rdata;
      end else if (state_q == ST_BADSEL) begin
        rdata_d = '0;
      end
      if ((state_q == ST_BUSY) && !w_slot_rdy) begin
        state_d = ST_BUSY;
      end else if (w_accept) begin
        if (w_sel_valid) begin
          state_d = ST_BUSY;
          idx_d   = up_sel_i[2:0];
        end else begin
          state_d = ST_BADSEL;
        end
      end else begin
        state_d = ST_IDLE;
      end
    end
  end

  always_ff @(posedge swclk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= ST_IDLE;
      idx_q   <= 3'd0;
      rdata_q <= 32'd0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      rdata_q <= rdata_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_opendap_ap_mux.sv
`default_nettype none
// ============================================================================
// Module   : tb_opendap_ap_mux
// Purpose  : Directed self-checking bench for opendap_ap_mux with N_APS=2,
//            BAD_SEL_ERR=1. Inputs change 1 time unit after a rising edge,
//            outputs are sampled mid-cycle.
// Revision : 1.0 - initial release
// ============================================================================
module tb_opendap_ap_mux;

  localparam int C_N = 2;

  logic          swclk = 1'b0;
  logic          rst_n;
  logic [7:0]    up_sel;
  logic [5:0]    up_addr;
  logic [31:0]   up_wdata;
  logic          up_wen, up_ren, up_abort;
  logic [31:0]   up_rdata;
  logic          up_rdy, up_err;
  logic [5:0]    dn_addr;
  logic [31:0]   dn_wdata;
  logic [C_N-1:0] dn_wen, dn_ren, dn_abort;
  logic [32*C_N-1:0] dn_rdata;
  logic [C_N-1:0] dn_rdy, dn_err;

  int n_total = 0;
  int n_bad   = 0;

  always #5 swclk = ~swclk;

  opendap_ap_mux #(.N_APS(C_N), .BAD_SEL_ERR(1'b1)) dut (
    .swclk_i    (swclk),
    .rst_ni     (rst_n),
    .up_sel_i   (up_sel),
    .up_addr_i  (up_addr),
    .up_wdata_i (up_wdata),
    .up_wen_i   (up_wen),
    .up_ren_i   (up_ren),
    .up_abort_i (up_abort),
    .up_rdata_o (up_rdata),
    .up_rdy_o   (up_rdy),
    .up_err_o   (up_err),
    .dn_addr_o  (dn_addr),
    .dn_wdata_o (dn_wdata),
    .dn_wen_o   (dn_wen),
    .dn_ren_o   (dn_ren),
    .dn_abort_o (dn_abort),
    .dn_rdata_i (dn_rdata),
    .dn_rdy_i   (dn_rdy),
    .dn_err_i   (dn_err)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=0x%08h exp=0x%08h", tag, got, exp);
    end
  endtask

  // Advance to 1 unit after the next rising edge.
  task automatic tick();
    @(posedge swclk);
    #1;
  endtask

  // Let combinational outputs settle after an input change.
  task automatic settle();
    #2;
  endtask

  initial begin
    rst_n = 1'b0; up_sel = '0; up_addr = '0; up_wdata = '0;
    up_wen = 1'b0; up_ren = 1'b0; up_abort = 1'b0;
    dn_rdata = '0; dn_rdy = '0; dn_err = '0;
    settle();
    check("rst_rdy",   32'(up_rdy),   32'd1);
    check("rst_err",   32'(up_err),   32'd0);
    check("rst_rdata", up_rdata,      32'd0);
    check("rst_dnstb", 32'({dn_wen, dn_ren, dn_abort}), 32'd0);
    tick(); tick();
    rst_n = 1'b1;
    tick();

    // ---- read with two wait cycles on slot 1 ----
    up_sel = 8'd1; up_ren = 1'b1; up_addr = 6'h0C; settle();
    check("rd_dnren",  32'(dn_ren),  32'h2);
    check("rd_dnaddr", 32'(dn_addr), 32'h0C);
    tick(); up_ren = 1'b0; settle();
    check("rd_dnren_off", 32'(dn_ren), 32'h0);
    check("rd_rdy_w1", 32'(up_rdy), 32'd0);
    tick(); settle();
    check("rd_rdy_w2", 32'(up_rdy), 32'd0);
    tick(); dn_rdy = 2'b10; dn_rdata[63:32] = 32'h12345678; settle();
    check("rd_rdy_done", 32'(up_rdy), 32'd1);
    check("rd_rdata",    up_rdata,    32'h12345678);
    check("rd_err",      32'(up_err), 32'd0);
    tick(); dn_rdy = '0; dn_rdata[63:32] = 32'hDEADBEEF; settle();
    check("rd_hold", up_rdata, 32'h12345678);

    // ---- write to slot 0 completing with error ----
    up_sel = 8'd0; up_wen = 1'b1; up_wdata = 32'hCAFEF00D; settle();
    check("wr_dnwen",   32'(dn_wen), 32'h1);
    check("wr_dnwdata", dn_wdata,    32'hCAFEF00D);
    tick(); up_wen = 1'b0; dn_rdy = 2'b01; dn_err = 2'b01; settle();
    check("wr_err", 32'(up_err), 32'd1);
    tick(); dn_rdy = '0; settle();
    check("wr_err_1cyc", 32'(up_err), 32'd0);
    dn_err = '0;

    // ---- nonexistent APSEL ----
    up_sel = 8'd5; up_ren = 1'b1; settle();
    check("bad_nostb", 32'({dn_wen, dn_ren}), 32'd0);
    tick(); up_ren = 1'b0; settle();
    check("bad_rdy",   32'(up_rdy), 32'd1);
    check("bad_err",   32'(up_err), 32'd1);
    check("bad_rdata", up_rdata,    32'd0);
    tick(); settle();
    check("bad_idle_err",   32'(up_err), 32'd0);
    check("bad_idle_rdata", up_rdata,    32'd0);

    // ---- abort while slot 0 stalls ----
    up_sel = 8'd0; up_ren = 1'b1; settle();
    tick(); up_ren = 1'b0; settle();
    check("ab_stall", 32'(up_rdy), 32'd0);
    tick(); up_abort = 1'b1; up_ren = 1'b1; settle();
    check("ab_dnabort", 32'(dn_abort), 32'h3);
    check("ab_noren",   32'(dn_ren),   32'h0);
    tick(); up_abort = 1'b0; up_ren = 1'b0; settle();
    check("ab_rdy", 32'(up_rdy), 32'd1);
    check("ab_err", 32'(up_err), 32'd0);

    // ---- back-to-back: slot1 read on slot0 completion cycle ----
    up_sel = 8'd0; up_ren = 1'b1; settle();
    tick(); up_ren = 1'b0; settle();
    tick(); dn_rdy = 2'b01; dn_rdata[31:0] = 32'h11112222;
    up_sel = 8'd1; up_ren = 1'b1; settle();
    check("b2b_dnren", 32'(dn_ren), 32'h2);
    check("b2b_rdata", up_rdata,    32'h11112222);
    tick(); up_ren = 1'b0; dn_rdata[63:32] = 32'h33334444; settle();
    check("b2b_not_idx0", 32'(up_rdy), 32'd0);
    dn_rdy = 2'b10; settle();
    check("b2b_idx1_rdy",   32'(up_rdy), 32'd1);
    check("b2b_idx1_rdata", up_rdata,    32'h33334444);
    tick(); dn_rdy = '0; settle();

    // ---- reset in the middle of an access ----
    up_sel = 8'd0; up_ren = 1'b1; settle();
    tick(); up_ren = 1'b0; dn_rdata[31:0] = 32'h55556666; settle();
    check("mr_busy", 32'(up_rdy), 32'd0);
    rst_n = 1'b0; settle();
    check("mr_rdy",   32'(up_rdy), 32'd1);
    check("mr_err",   32'(up_err), 32'd0);
    check("mr_rdata", up_rdata,    32'd0);
    tick(); rst_n = 1'b1; dn_rdy = 2'b01; dn_err = 2'b01; settle();
    check("mr_noerr1", 32'(up_err), 32'd0);
    tick(); settle();
    check("mr_noerr2", 32'(up_err), 32'd0);
    dn_rdy = '0; dn_err = '0;
    tick();

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/opendap_ap_mux.md
OPENDAP_AP_MUX -- requirements
Module: opendap_ap_mux

Interface
REQ-001 SHALL have parameter N_APS, default 2, meaning number of downstream APs (1..8); the AP at APSEL=i connects to downstream slot i.
REQ-002 SHALL have parameter BAD_SEL_ERR, default 1, meaning an access to APSEL >= N_APS completes with err=1 (0: completes silently).
REQ-003 SHALL have one clock and an asynchronous active-low reset: swclk input 1, rst_n input 1.
REQ-004 SHALL have input ports from the DP: up_sel input 8 (APSEL); up_addr input 6; up_wdata input 32; up_wen input 1; up_ren input 1; up_abort input 1.
REQ-005 SHALL have output ports to the DP: up_rdata output 32; up_rdy output 1; up_err output 1.
REQ-006 SHALL have downstream output ports: dn_addr output 6; dn_wdata output 32; dn_wen output N_APS; dn_ren output N_APS; dn_abort output N_APS.
REQ-007 SHALL have downstream input ports: dn_rdata input 32*N_APS (slot i at bits [32i+31:32i]); dn_rdy input N_APS; dn_err input N_APS.

Function
REQ-008 SHALL implement states IDLE, BUSY (valid AP in flight, latched index idx) and BADSEL (nonexistent AP, one cycle).
REQ-009 SHALL define accept = (up_wen|up_ren) && up_rdy.
- An accept in IDLE, or on the BUSY completion cycle, starts a new access.
- up_wen/up_ren while up_rdy=0 SHALL be ignored: not forwarded, no state change.
REQ-010 SHALL forward each accept combinationally in the same cycle when up_sel < N_APS.
- Strobe goes on dn_wen[up_sel] or dn_ren[up_sel] only; all other strobe bits are 0.
- dn_addr=up_addr and dn_wdata=up_wdata, passed straight through.
- up_sel is latched into idx and the block enters BUSY.
REQ-011 SHALL handle an accept with up_sel >= N_APS as follows.
- No downstream strobe.
- Enter BADSEL.
- The next cycle: up_rdy=1, up_rdata=0, up_err=BAD_SEL_ERR.
- Then return to IDLE.
REQ-012 SHALL drive up_rdy as follows: IDLE 1; BADSEL 1; BUSY dn_rdy[idx].
REQ-013 SHALL drive up_err as follows.
- BUSY: dn_err[idx] && dn_rdy[idx], on the completion cycle only.
- BADSEL: as REQ-011.
- All other cycles: 0.
REQ-014 SHALL drive up_rdata as follows.
- BUSY: dn_rdata[idx].
- IDLE: rdata_q, captured from dn_rdata[idx] on the BUSY completion cycle (0 after BADSEL).
- The value is therefore held until the next accept.
REQ-015 SHALL handle a BUSY completion cycle (dn_rdy[idx]=1) as follows: with no accept go to IDLE; with an accept follow REQ-010/011 directly.
REQ-016 SHALL, on up_abort=1, drive dn_abort to all-ones in the same cycle.
- Next state is IDLE from any state.
- up_err is 0 that next cycle.
- rdata_q is unchanged.
- An up_wen/up_ren in the abort cycle is ignored.
REQ-017 SHALL ensure at most one downstream AP has an access in flight at any time; no dn_wen/dn_ren bit is asserted while in BUSY before completion.
REQ-018 SHALL keep all outputs free of X when any non-selected slot's dn_* inputs are X.

Reset
REQ-019 SHALL on rst_n low, asynchronously:
- enter IDLE, with idx=0 and rdata_q=0;
- drive up_rdy=1, up_err=0, up_rdata=0;
- hold dn_wen, dn_ren and dn_abort at 0 (combinational, given inactive upstream strobes).
REQ-020 SHALL treat reset during BUSY as abandoning the access: no completion is reported afterwards, and downstream APs are reset by the same rst_n.

Verification
REQ-021 SHALL cover the following directed scenarios.
- Read, 2-cycle wait: N_APS=2, up_sel=1, up_ren with up_addr=0x0C; slot1 holds rdy=0 for 2 cycles, then rdy=1 with rdata=0x12345678.
  Required: dn_ren=2'b10 for one cycle; up_rdy 0,0,1; up_rdata stays 0x12345678 in IDLE.
- Write with error: up_sel=0, up_wen with wdata=0xCAFEF00D; slot0 rdy=1 with err=1 next cycle.
  Required: up_err=1 for exactly one cycle; dn_wdata=0xCAFEF00D.
- Bad select: up_sel=5 with N_APS=2, up_ren.
  Required: no dn strobe; next cycle up_rdy=1, up_err=1 (BAD_SEL_ERR=1) and up_rdata=0.
- Abort: slot0 stalled in BUSY, then up_abort=1.
  Required: dn_abort=2'b11 that cycle; up_rdy=1 and up_err=0 the next cycle, even with slot0 rdy=0.
- Back-to-back: up_ren to slot1 issued on the completion cycle of a slot0 read.
  Required: dn_ren=2'b10 that cycle; idx=1; the slot0 result is not lost on up_rdata during that cycle.
- Mid-access reset: rst_n asserted in BUSY.
  Required: immediate up_rdy=1, up_err=0, up_rdata=0; later slot rdy pulses produce no up_err.
